// File: rtl/ag6502_irq_ctrl_pkg.sv
// rtl/ag6502_irq_ctrl_pkg.sv - register offsets, fixed addresses and priority helper for the ag6502 IRQ controller
package ag6502_irq_ctrl_pkg;

    localparam logic [1:0]  IRQ_REG_PEND = 2'd0;
    localparam logic [1:0]  IRQ_REG_MASK = 2'd1;
    localparam logic [1:0]  IRQ_REG_EDGE = 2'd2;
    localparam logic [1:0]  IRQ_REG_TOP  = 2'd3;

    localparam logic [15:0] NMI_VEC_ADDR = 16'hFFFA;
    localparam logic [15:0] IRQ_VEC_ADDR = 16'hFFFE;
    localparam logic [7:0]  TOP_NONE     = 8'h80;

    // Lowest set bit wins; returns 0 for an all-zero vector (caller checks "any").
    function automatic logic [2:0] lowest_idx(input logic [7:0] v);
        lowest_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) lowest_idx = 3'(i);
        end
    endfunction

endpackage

// File: rtl/ag6502_irq_ctrl_if.sv
// rtl/ag6502_irq_ctrl_if.sv - CPU-side register bus between the ag6502 core and the IRQ controller
interface ag6502_irq_ctrl_if;
    logic [15:0] ab;
    logic        read;
    logic [7:0]  db_out;
    logic        bus_stb;
    logic [7:0]  rd_data;
    logic        rd_sel;

    modport master (
        output ab, read, db_out, bus_stb,
        input  rd_data, rd_sel
    );

    modport slave (
        input  ab, read, db_out, bus_stb,
        output rd_data, rd_sel
    );
endinterface

// File: rtl/ag6502_irq_sync.sv
// rtl/ag6502_irq_sync.sv - 2-flop synchronizer with a third flop for rising-edge detect
module ag6502_irq_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic lvl,
    output logic rise
);
    logic s1, s2, s3;

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign lvl  = s2;
    assign rise = s2 & ~s3;
endmodule

// File: rtl/ag6502_irq_ctrl.sv
// rtl/ag6502_irq_ctrl.sv - IRQ/NMI controller for ag6502; AG6502_IRQ_VECTOR_EN adds per-source vector override
module ag6502_irq_ctrl
    import ag6502_irq_ctrl_pkg::*;
#(
    parameter int          NSRC      = 8,
    parameter logic [15:0] BASE_ADDR = 16'hD000,
    parameter logic [15:0] VEC_BASE  = 16'hFF00
) (
    input  logic             phi_0,
    input  logic             rst,
    ag6502_irq_ctrl_if.slave bus,
    input  logic [NSRC-1:0]  src,
    input  logic             nmi_src,
    output logic             irq,
    output logic             nmi
);
    localparam logic [7:0] SRC_VALID = 8'((9'd1 << NSRC) - 9'd1);

    logic [7:0] lvl, rise;
    logic       nmi_rise;

    for (genvar i = 0; i < 8; i++) begin : g_src
        if (i < NSRC) begin : g_on
            ag6502_irq_sync u_sync (
                .clk  (phi_0),
                .rst  (rst),
                .din  (src[i]),
                .lvl  (lvl[i]),
                .rise (rise[i])
            );
        end else begin : g_off
            assign lvl[i]  = 1'b0;
            assign rise[i] = 1'b0;
        end
    end

    ag6502_irq_sync u_nmi_sync (
        .clk  (phi_0),
        .rst  (rst),
        .din  (nmi_src),
        .lvl  (),
        .rise (nmi_rise)
    );

    logic       hit, wr, nmi_clr;
    logic [1:0] off;

    assign hit     = bus.ab[15:2] == BASE_ADDR[15:2];
    assign off     = bus.ab[1:0];
    assign wr      = bus.bus_stb & ~bus.read & hit;
    assign nmi_clr = bus.bus_stb & bus.read & (bus.ab == NMI_VEC_ADDR);

    logic [7:0] pend, mask, edge_sel, pend_next, w1c, active;
    logic       any, nmi_pend;
    logic [2:0] idx;

    assign active = pend & mask;
    assign any    = |active;
    assign idx    = lowest_idx(active);

    // A new edge in the same cycle as its W1C keeps the bit set; level bits ignore W1C.
    always_comb begin
        w1c = 8'h00;
        if (wr && off == IRQ_REG_PEND) w1c = bus.db_out;
        pend_next = ((edge_sel & ((pend & ~w1c) | rise)) | (~edge_sel & lvl)) & SRC_VALID;
    end

    always_ff @(posedge phi_0) begin
        if (!rst) begin
            pend     <= 8'h00;
            mask     <= 8'h00;
            edge_sel <= 8'h00;
            nmi_pend <= 1'b0;
            irq      <= 1'b1;
            nmi      <= 1'b1;
        end else begin
            pend <= pend_next;
            if (wr && off == IRQ_REG_MASK) mask     <= bus.db_out & SRC_VALID;
            if (wr && off == IRQ_REG_EDGE) edge_sel <= bus.db_out & SRC_VALID;
            irq      <= ~any;
            nmi_pend <= nmi_rise | (nmi_pend & ~nmi_clr);
            nmi      <= ~nmi_pend;
        end
    end

`ifdef AG6502_IRQ_VECTOR_EN
    logic vflag;

    // Any strobe re-evaluates vflag, so only a $FFFE fetch with a live request arms the $FFFF override.
    always_ff @(posedge phi_0) begin
        if (!rst) begin
            vflag <= 1'b0;
        end else if (bus.bus_stb) begin
            vflag <= bus.read & (bus.ab == IRQ_VEC_ADDR) & any;
        end
    end
`endif

    logic [7:0] rd_data;
    logic       rd_sel;

    always_comb begin
        rd_data = 8'h00;
        rd_sel  = 1'b0;
        if (bus.read && hit) begin
            rd_sel = 1'b1;
            case (off)
                IRQ_REG_PEND: rd_data = pend;
                IRQ_REG_MASK: rd_data = mask;
                IRQ_REG_EDGE: rd_data = edge_sel;
                default:      rd_data = any ? {5'b00000, idx} : TOP_NONE;
            endcase
        end
`ifdef AG6502_IRQ_VECTOR_EN
        if (bus.read && bus.ab == IRQ_VEC_ADDR && any) begin
            rd_sel  = 1'b1;
            rd_data = VEC_BASE[7:0] + {4'b0000, idx, 1'b0};
        end
        if (bus.read && bus.ab == (IRQ_VEC_ADDR + 16'd1) && vflag) begin
            rd_sel  = 1'b1;
            rd_data = VEC_BASE[15:8];
        end
`endif
    end

    assign bus.rd_data = rd_data;
    assign bus.rd_sel  = rd_sel;
endmodule

// File: tb/tb_ag6502_irq_ctrl.sv
// tb/tb_ag6502_irq_ctrl.sv - scoreboard bench for ag6502_irq_ctrl with a cycle-level reference model
module tb_ag6502_irq_ctrl;
    localparam logic [15:0] BASE = 16'hD000;
    localparam logic [15:0] VEC  = 16'hFF00;

    logic       phi_0 = 1'b0;
    logic       rst   = 1'b0;
    logic [7:0] src   = 8'h00;
    logic       nmi_src = 1'b0;
    logic       irq, nmi;

    ag6502_irq_ctrl_if bus();

    ag6502_irq_ctrl #(.NSRC(8), .BASE_ADDR(BASE), .VEC_BASE(VEC)) dut (
        .phi_0   (phi_0),
        .rst     (rst),
        .bus     (bus),
        .src     (src),
        .nmi_src (nmi_src),
        .irq     (irq),
        .nmi     (nmi)
    );

    always #5 phi_0 = ~phi_0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       sel;
        logic [7:0] data;
        string      name;
    } rd_exp_t;

    rd_exp_t rq[$];
    logic    rd_cyc = 1'b0;
    bit      chk = 1'b0;

    logic [7:0] m_pend, m_mask, m_edge;
    logic       m_npend, m_vflag, exp_irq, exp_nmi;
    logic [8:0] hist[$];

    // Reference model: each history entry is {nmi_src, src} seen at one edge; a request is
    // visible to the latching logic two edges after it was sampled.
    task automatic model_step();
        logic [7:0] lvl, rise, w1c;
        logic       nrise, hit, any_old;
        if (!rst) begin
            m_pend = 0; m_mask = 0; m_edge = 0; m_npend = 0; m_vflag = 0;
            exp_irq = 1; exp_nmi = 1;
            hist = '{9'd0, 9'd0, 9'd0, 9'd0};
            chk = 1;
            return;
        end
        hist.push_front({nmi_src, src});
        void'(hist.pop_back());
        lvl   = hist[2][7:0];
        rise  = hist[2][7:0] & ~hist[3][7:0];
        nrise = hist[2][8] & ~hist[3][8];
        any_old = |(m_pend & m_mask);
        exp_irq = ~any_old;
        exp_nmi = ~m_npend;
        hit = bus.ab[15:2] == BASE[15:2];
        w1c = (bus.bus_stb && !bus.read && hit && bus.ab[1:0] == 2'd0) ? bus.db_out : 8'h00;
        for (int i = 0; i < 8; i++)
            m_pend[i] = m_edge[i] ? (rise[i] | (m_pend[i] & ~w1c[i])) : lvl[i];
        if (bus.bus_stb && !bus.read && hit && bus.ab[1:0] == 2'd1) m_mask = bus.db_out;
        if (bus.bus_stb && !bus.read && hit && bus.ab[1:0] == 2'd2) m_edge = bus.db_out;
        if (bus.bus_stb && bus.read && bus.ab == 16'hFFFA) m_npend = nrise;
        else m_npend = m_npend | nrise;
        if (bus.bus_stb) m_vflag = bus.read && bus.ab == 16'hFFFE && any_old;
    endtask

    function automatic rd_exp_t exp_read(input logic [15:0] a);
        rd_exp_t    e;
        logic [7:0] v;
        int         idx;
        v = m_pend & m_mask;
        idx = -1;
        for (int i = 7; i >= 0; i--) if (v[i]) idx = i;
        e.sel = 0; e.data = 0; e.name = $sformatf("rd_%h", a);
        if (a[15:2] == BASE[15:2]) begin
            e.sel = 1;
            case (a[1:0])
                2'd0: e.data = m_pend;
                2'd1: e.data = m_mask;
                2'd2: e.data = m_edge;
                default: e.data = (idx < 0) ? 8'h80 : 8'(idx);
            endcase
        end
`ifdef AG6502_IRQ_VECTOR_EN
        else if (a == 16'hFFFE && idx >= 0) begin
            e.sel = 1; e.data = VEC[7:0] + 8'(2 * idx);
        end else if (a == 16'hFFFF && m_vflag) begin
            e.sel = 1; e.data = VEC[15:8];
        end
`endif
        return e;
    endfunction

    initial forever begin
        @(posedge phi_0);
        model_step();
    end

    initial forever begin
        rd_exp_t e;
        @(negedge phi_0);
        if (chk) begin
            checks++;
            if (irq !== exp_irq) begin
                errors++; $display("FAIL irq: got %b expected %b at %0t", irq, exp_irq, $time);
            end
            checks++;
            if (nmi !== exp_nmi) begin
                errors++; $display("FAIL nmi: got %b expected %b at %0t", nmi, exp_nmi, $time);
            end
            if (rd_cyc) begin
                checks++;
                if (rq.size() == 0) begin
                    errors++; $display("FAIL rd_queue: read issued with no expectation at %0t", $time);
                end else begin
                    e = rq.pop_front();
                    if (bus.rd_sel !== e.sel) begin
                        errors++; $display("FAIL %s rd_sel: got %b expected %b at %0t", e.name, bus.rd_sel, e.sel, $time);
                    end else if (e.sel) begin
                        checks++;
                        if (bus.rd_data !== e.data) begin
                            errors++; $display("FAIL %s rd_data: got %h expected %h at %0t", e.name, bus.rd_data, e.data, $time);
                        end
                    end
                end
            end else if (bus.rd_sel !== 1'b0) begin
                checks++; errors++;
                $display("FAIL rd_sel_idle: got %b expected 0 at %0t", bus.rd_sel, $time);
            end
        end
    end

    task automatic tick();
        @(posedge phi_0);
        #1;
    endtask

    task automatic bus_idle();
        bus.ab = 16'h0000; bus.read = 1'b1; bus.db_out = 8'h00; bus.bus_stb = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic do_write(input logic [1:0] off, input logic [7:0] d);
        bus.ab = BASE + 16'(off); bus.read = 1'b0; bus.db_out = d; bus.bus_stb = 1'b1;
        tick();
        bus_idle();
    endtask

    task automatic issue_read(input logic [15:0] a, input rd_exp_t e);
        rq.push_back(e);
        bus.ab = a; bus.read = 1'b1; bus.bus_stb = 1'b1; rd_cyc = 1'b1;
        tick();
        rd_cyc = 1'b0;
        bus_idle();
    endtask

    task automatic read_model(input logic [15:0] a);
        issue_read(a, exp_read(a));
    endtask

    task automatic read_const(input logic [15:0] a, input logic sel, input logic [7:0] d, input string nm);
        rd_exp_t e;
        e.sel = sel; e.data = d; e.name = nm;
        issue_read(a, e);
    endtask

    task automatic do_reset();
        bus_idle();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    initial begin
        bus_idle();
        ticks(3);
        rst = 1'b1;

        // Edge source: single-cycle pulse is latched, W1C releases irq
        do_write(2'd1, 8'h01);
        do_write(2'd2, 8'h01);
        src[0] = 1'b1; tick(); src[0] = 1'b0;
        ticks(4);
        read_const(BASE + 16'd0, 1'b1, 8'h01, "t1_pend");
        do_write(2'd0, 8'h01);
        ticks(2);
        read_const(BASE + 16'd3, 1'b1, 8'h80, "t1_top_after_w1c");

        // Level source ignores W1C and follows the pin
        do_reset();
        do_write(2'd2, 8'h00);
        do_write(2'd1, 8'h04);
        src[2] = 1'b1;
        ticks(4);
        read_const(BASE + 16'd3, 1'b1, 8'h02, "t2_top");
        do_write(2'd0, 8'h04);
        ticks(1);
        read_const(BASE + 16'd0, 1'b1, 8'h04, "t2_pend_after_w1c");
        src[2] = 1'b0;
        ticks(4);

        // Priority and mask
        do_reset();
        do_write(2'd2, 8'h28);
        src[5] = 1'b1; src[3] = 1'b1; tick(); src[5] = 1'b0; src[3] = 1'b0;
        ticks(3);
        do_write(2'd1, 8'h28);
        read_const(BASE + 16'd3, 1'b1, 8'h03, "t3_top_28");
        do_write(2'd1, 8'h20);
        read_const(BASE + 16'd3, 1'b1, 8'h05, "t3_top_20");
        do_write(2'd1, 8'h00);
        read_const(BASE + 16'd3, 1'b1, 8'h80, "t3_top_00");
        read_const(BASE + 16'd0, 1'b1, 8'h28, "t3_pend");
        ticks(2);

        // Set/clear race: src[1] edge reaches PEND on the W1C edge
        do_reset();
        do_write(2'd2, 8'h02);
        src[1] = 1'b1; tick(); tick();
        do_write(2'd0, 8'h02);
        read_const(BASE + 16'd0, 1'b1, 8'h02, "t4_race");
        src[1] = 1'b0;

        // NMI: held across other reads, cleared by vector fetch, dropped by reset
        do_reset();
        nmi_src = 1'b1;
        ticks(5);
        read_model(BASE + 16'd1);
        read_const(16'h1234, 1'b0, 8'h00, "t5_other");
        read_const(16'hFFFA, 1'b0, 8'h00, "t5_fffa");
        ticks(2);
        nmi_src = 1'b0; ticks(2);
        nmi_src = 1'b1; ticks(5);
        do_write(2'd1, 8'hFF);
        do_write(2'd2, 8'hFF);
        src = 8'hFF; ticks(4); src = 8'h00;
        do_reset();
        nmi_src = 1'b0;
        ticks(4);

        // Vector override
        do_reset();
        do_write(2'd2, 8'h40);
        do_write(2'd1, 8'h40);
        src[6] = 1'b1; tick(); src[6] = 1'b0;
        ticks(4);
`ifdef AG6502_IRQ_VECTOR_EN
        read_const(16'hFFFE, 1'b1, 8'h0C, "t6_fffe");
        read_const(16'hFFFF, 1'b1, 8'hFF, "t6_ffff");
        do_write(2'd0, 8'h40);
        ticks(2);
        read_const(16'hFFFE, 1'b0, 8'h00, "t6_fffe_none");
`else
        read_const(16'hFFFE, 1'b0, 8'h00, "t6_fffe_nodecode");
        read_const(16'hFFFF, 1'b0, 8'h00, "t6_ffff_nodecode");
`endif

        // Randomized traffic against the model
        do_reset();
        for (int n = 0; n < 600; n++) begin
            case ($urandom_range(0, 9))
                0, 1: do_write(2'($urandom_range(0, 3)), 8'($urandom));
                2, 3: read_model(BASE + 16'($urandom_range(0, 3)));
                4:    read_model(16'hFFFA);
                5: begin
                    read_model(16'hFFFE);
                    read_model(16'hFFFF);
                end
                6:    begin src = 8'($urandom); tick(); end
                7:    begin nmi_src = 1'($urandom); tick(); end
                8:    ticks($urandom_range(1, 3));
                default: begin
                    if ($urandom_range(0, 7) == 0) do_reset();
                    else tick();
                end
            endcase
        end
        ticks(6);

        checks++;
        if (rq.size() != 0) begin
            errors++; $display("FAIL rd_queue_drain: %0d left, expected 0", rq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
